// File: rtl/simple_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : simple_datapath_if
// Description : Control and observation bundle for simple_datapath.
//               The control side drives every bus-source select, load
//               enable and ALU strobe. The datapath side returns the
//               encoder request vector, the current bus value and the
//               architectural registers so that a controller or bench can
//               watch state without hierarchical references.
// Ports       : (interface signals)
//   R0out..R15out, HIout, LOout, ZHighout, Zlowout, PCout, MDRout,
//   InPortout, Cout               bus-source selects
//   R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin   load enables
//   Read       MDR input mux (1 = Mdatain, 0 = bus)
//   IncPC      ALU computes bus+1
//   AND        forces ALU AND
//   operation  5-bit ALU opcode
//   Mdatain    memory read data
//   encoder_input  one-hot bus request vector
//   bus, pc, ir, mar, mdr, y, z, r3, r4, r7   observed state
// Revision    : 1.0 - initial release
// ============================================================================
interface simple_datapath_if;
  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
  logic        HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic        R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin;
  logic        Read, IncPC, AND;
  logic [4:0]  operation;
  logic [31:0] Mdatain;
  logic [31:0] encoder_input;
  logic [31:0] bus, pc, ir, mar, mdr, y, r3, r4, r7;
  logic [63:0] z;

  modport master (
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout,
           R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin,
           Read, IncPC, AND, operation, Mdatain,
    input  encoder_input, bus, pc, ir, mar, mdr, y, z, r3, r4, r7
  );

  modport slave (
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout,
           R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin,
           Read, IncPC, AND, operation, Mdatain,
    output encoder_input, bus, pc, ir, mar, mdr, y, z, r3, r4, r7
  );
endinterface
`default_nettype wire

// File: rtl/simple_datapath.sv
`default_nettype none
// ============================================================================
// Module      : simple_datapath
// Description : Bus-based 32-bit CPU datapath. R0-R15, PC, IR, MAR, MDR, Y,
//               64-bit Z, HI, LO, in-port and a sign-extended constant share
//               one 32-bit bus chosen by a highest-index priority encoder.
//               The ALU (A = Y, B = bus) writes Z.
// Ports       :
//   Clock  in  rising-edge clock
//   Clear  in  asynchronous active-low reset
//   dp     simple_datapath_if.slave  strobes in, encoder vector/state out
// Options     : DATAPATH_MULDIV_EN - when defined, opcode 01100 is signed
//               MUL (64-bit) and 01101 is signed DIV (Z = {rem, quot},
//               divide by zero gives 0); otherwise both produce 0.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_datapath (
  input  wire logic          Clock,
  input  wire logic          Clear,
  simple_datapath_if.slave   dp
);

  // Architectural registers with a load path. R0-R2, R5, R6, R8-R15, HI,
  // LO and the in-port have no load enable, so they read as constant 0.
  logic [31:0] r3, r4, r7, pc, ir, mar, mdr, y;
  logic [63:0] z;

  logic [31:0] bus;
  logic [31:0] c_sext;
  logic [31:0] enc_in;
  logic [4:0]  enc_sel;
  logic [31:0] src [32];
  logic [63:0] alu_res;

  // --------------------------------------------------------------------------
  // Bus request vector and priority encoder (highest set index wins)
  // --------------------------------------------------------------------------
  assign enc_in = {8'd0,
                   dp.Cout, dp.InPortout, dp.MDRout, dp.PCout,
                   dp.Zlowout, dp.ZHighout, dp.LOout, dp.HIout,
                   dp.R15out, dp.R14out, dp.R13out, dp.R12out,
                   dp.R11out, dp.R10out, dp.R9out, dp.R8out,
                   dp.R7out, dp.R6out, dp.R5out, dp.R4out,
                   dp.R3out, dp.R2out, dp.R1out, dp.R0out};

  always_comb begin
    enc_sel = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (enc_in[i]) enc_sel = i[4:0];
    end
  end

  assign c_sext = {{13{ir[18]}}, ir[18:0]};

  always_comb begin
    for (int i = 0; i < 32; i++) src[i] = 32'd0;
    src[3]  = r3;
    src[4]  = r4;
    src[7]  = r7;
    src[18] = z[63:32];
    src[19] = z[31:0];
    src[20] = pc;
    src[21] = mdr;
    src[23] = c_sext;
  end

  // An empty request vector must give 0 rather than whatever index 0 holds.
  assign bus = (enc_in == 32'd0) ? 32'd0 : src[enc_sel];

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt;
  logic [63:0] ror_w, rol_w;
  logic [31:0] shra_w;

  assign alu_a  = y;
  assign alu_b  = bus;
  assign shamt  = alu_b[4:0];
  // Rotates done by shifting a doubled copy so a zero amount needs no
  // special case.
  assign ror_w  = {alu_a, alu_a} >> shamt;
  assign rol_w  = {alu_a, alu_a} << shamt;
  assign shra_w = $signed(alu_a) >>> shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] mul_full;
  logic signed [31:0] div_q, div_r;
  assign mul_full = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
  assign div_q    = (alu_b == 32'd0) ? 32'sd0 : $signed(alu_a) / $signed(alu_b);
  assign div_r    = (alu_b == 32'd0) ? 32'sd0 : $signed(alu_a) % $signed(alu_b);
`endif

  // IncPC and AND are tested first so an undriven opcode never reaches Z.
  always_comb begin
    alu_res = 64'd0;
    if (dp.IncPC) begin
      alu_res = {32'd0, alu_b + 32'd1};
    end else if (dp.AND) begin
      alu_res = {32'd0, alu_a & alu_b};
    end else begin
      case (dp.operation)
        5'b00011: alu_res = {32'd0, alu_a + alu_b};
        5'b00100: alu_res = {32'd0, alu_a - alu_b};
        5'b00101: alu_res = {32'd0, alu_a & alu_b};
        5'b00110: alu_res = {32'd0, alu_a | alu_b};
        5'b00111: alu_res = {32'd0, alu_a >> shamt};
        5'b01000: alu_res = {32'd0, shra_w};
        5'b01001: alu_res = {32'd0, alu_a << shamt};
        5'b01010: alu_res = {32'd0, ror_w[31:0]};
        5'b01011: alu_res = {32'd0, rol_w[63:32]};
`ifdef DATAPATH_MULDIV_EN
        5'b01100: alu_res = mul_full;
        5'b01101: alu_res = {div_r, div_q};
`else
        5'b01100: alu_res = 64'd0;
        5'b01101: alu_res = 64'd0;
`endif
        5'b01110: alu_res = {32'd0, 32'd0 - alu_b};
        5'b01111: alu_res = {32'd0, ~alu_b};
        default:  alu_res = 64'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers. Every load samples the pre-edge bus, so a register may source
  // the bus and load in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r3  <= 32'd0;
      r4  <= 32'd0;
      r7  <= 32'd0;
      pc  <= 32'd0;
      ir  <= 32'd0;
      mar <= 32'd0;
      mdr <= 32'd0;
      y   <= 32'd0;
      z   <= 64'd0;
    end else begin
      if (dp.R3in)  r3  <= bus;
      if (dp.R4in)  r4  <= bus;
      if (dp.R7in)  r7  <= bus;
      if (dp.PCin)  pc  <= bus;
      if (dp.IRin)  ir  <= bus;
      if (dp.MARin) mar <= bus;
      if (dp.MDRin) mdr <= dp.Read ? dp.Mdatain : bus;
      if (dp.Yin)   y   <= bus;
      if (dp.Zin)   z   <= alu_res;
    end
  end

  assign dp.encoder_input = enc_in;
  assign dp.bus = bus;
  assign dp.pc  = pc;
  assign dp.ir  = ir;
  assign dp.mar = mar;
  assign dp.mdr = mdr;
  assign dp.y   = y;
  assign dp.z   = z;
  assign dp.r3  = r3;
  assign dp.r4  = r4;
  assign dp.r7  = r7;

endmodule
`default_nettype wire

// File: tb/tb_simple_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_datapath
// Description : Self-checking bench for simple_datapath. Expected values are
//               queued when a step is driven and compared when the DUT has
//               produced them (combinational after settling, registers after
//               the next rising edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_datapath;

  localparam int SEL_BUS = 0;
  localparam int SEL_PC  = 1;
  localparam int SEL_IR  = 2;
  localparam int SEL_MAR = 3;
  localparam int SEL_MDR = 4;
  localparam int SEL_Y   = 5;
  localparam int SEL_Z   = 6;
  localparam int SEL_R3  = 7;
  localparam int SEL_R4  = 8;
  localparam int SEL_R7  = 9;
  localparam int SEL_ENC = 10;

  logic Clock;
  logic Clear;
  int   total;
  int   bad;

  string       tag_q [$];
  int          sel_q [$];
  logic [63:0] exp_q [$];

  simple_datapath_if dp ();

  simple_datapath dut (
    .Clock (Clock),
    .Clear (Clear),
    .dp    (dp.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic string sel_name(input int s);
    case (s)
      SEL_BUS: return "bus";
      SEL_PC:  return "pc";
      SEL_IR:  return "ir";
      SEL_MAR: return "mar";
      SEL_MDR: return "mdr";
      SEL_Y:   return "y";
      SEL_Z:   return "z";
      SEL_R3:  return "r3";
      SEL_R4:  return "r4";
      SEL_R7:  return "r7";
      default: return "enc";
    endcase
  endfunction

  function automatic logic [63:0] observe(input int s);
    case (s)
      SEL_BUS: return {32'd0, dp.bus};
      SEL_PC:  return {32'd0, dp.pc};
      SEL_IR:  return {32'd0, dp.ir};
      SEL_MAR: return {32'd0, dp.mar};
      SEL_MDR: return {32'd0, dp.mdr};
      SEL_Y:   return {32'd0, dp.y};
      SEL_Z:   return dp.z;
      SEL_R3:  return {32'd0, dp.r3};
      SEL_R4:  return {32'd0, dp.r4};
      SEL_R7:  return {32'd0, dp.r7};
      default: return {32'd0, dp.encoder_input};
    endcase
  endfunction

  // Independent reference for the opcode table (A = Y, B = bus).
  function automatic logic [63:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic signed [63:0] pa, pb;
    logic signed [31:0] q, m;
    r = a;
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b00111: return {32'd0, a >> b[4:0]};
      5'b01000: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]};
        return {32'd0, r};
      end
      5'b01001: return {32'd0, a << b[4:0]};
      5'b01010: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[0], r[31:1]};
        return {32'd0, r};
      end
      5'b01011: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], r[31]};
        return {32'd0, r};
      end
`ifdef DATAPATH_MULDIV_EN
      5'b01100: begin
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        return pa * pb;
      end
      5'b01101: begin
        if (b == 32'd0) return 64'd0;
        q = $signed(a) / $signed(b);
        m = $signed(a) % $signed(b);
        return {m, q};
      end
`endif
      5'b01110: return {32'd0, ~b + 32'd1};
      5'b01111: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: obs=0x%016h exp=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input int s, input logic [63:0] v);
    tag_q.push_back(sel_name(s));
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    string t;
    int s;
    logic [63:0] v;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = exp_q.pop_front();
      check(t, observe(s), v);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic expect_all_zero();
    for (int s = 0; s <= SEL_ENC; s++) expect_val(s, 64'd0);
  endtask

  task automatic clear_strobes();
    dp.R0out = 0; dp.R1out = 0; dp.R2out = 0; dp.R3out = 0;
    dp.R4out = 0; dp.R5out = 0; dp.R6out = 0; dp.R7out = 0;
    dp.R8out = 0; dp.R9out = 0; dp.R10out = 0; dp.R11out = 0;
    dp.R12out = 0; dp.R13out = 0; dp.R14out = 0; dp.R15out = 0;
    dp.HIout = 0; dp.LOout = 0; dp.ZHighout = 0; dp.Zlowout = 0;
    dp.PCout = 0; dp.MDRout = 0; dp.InPortout = 0; dp.Cout = 0;
    dp.R3in = 0; dp.R4in = 0; dp.R7in = 0; dp.PCin = 0; dp.IRin = 0;
    dp.MARin = 0; dp.MDRin = 0; dp.Yin = 0; dp.Zin = 0;
    dp.Read = 0; dp.IncPC = 0; dp.AND = 0;
    dp.operation = 5'd0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_strobes();
    dp.Mdatain = v;
    dp.Read = 1; dp.MDRin = 1;
    expect_val(SEL_MDR, {32'd0, v});
    tick();
  endtask

  logic [31:0] ld_vals [3];
  int          ld_dst  [3];
  logic [31:0] pair_a  [2];
  logic [31:0] pair_b  [2];
  logic [4:0]  ops     [15];
  logic [63:0] exp_z;

  initial begin
    total = 0;
    bad   = 0;
    ld_vals = '{32'h22, 32'h24, 32'h28};
    ld_dst  = '{SEL_R3, SEL_R7, SEL_R4};
    pair_a  = '{32'hFFFFFFFE, 32'h80000011};
    pair_b  = '{32'h00000003, 32'h00000024};
    ops     = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                5'b01101, 5'b01110, 5'b01111, 5'b00000, 5'b10000};
    exp_z = 64'd0;

    // Reset state
    clear_strobes();
    dp.Mdatain = 32'd0;
    Clear = 1'b1;
    #2 Clear = 1'b0;
    #10;
    expect_all_zero();
    settle();
    @(posedge Clock);
    #1 Clear = 1'b1;

    // Register loads through MDR
    for (int k = 0; k < 3; k++) begin
      load_mdr(ld_vals[k]);
      clear_strobes();
      dp.MDRout = 1;
      case (k)
        0:       dp.R3in = 1;
        1:       dp.R7in = 1;
        default: dp.R4in = 1;
      endcase
      expect_val(SEL_BUS, {32'd0, ld_vals[k]});
      settle();
      expect_val(ld_dst[k], {32'd0, ld_vals[k]});
      tick();
    end

    // Fetch T0: opcode left undriven-looking to show IncPC ignores it
    clear_strobes();
    dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; dp.Zin = 1;
    dp.operation = 5'bxxxxx;
    expect_val(SEL_ENC, 64'h0000_0000_0010_0000);
    settle();
    expect_val(SEL_MAR, 64'd0);
    expect_val(SEL_Z, 64'd1);
    tick();
    // T1
    clear_strobes();
    dp.Zlowout = 1; dp.PCin = 1; dp.Read = 1; dp.MDRin = 1;
    dp.Mdatain = 32'h2A2B8000;
    expect_val(SEL_BUS, 64'd1);
    settle();
    expect_val(SEL_PC, 64'd1);
    expect_val(SEL_MDR, 64'h2A2B8000);
    tick();
    // T2
    clear_strobes();
    dp.MDRout = 1; dp.IRin = 1;
    expect_val(SEL_IR, 64'h2A2B8000);
    tick();
    // Constant with IR[18] clear
    clear_strobes();
    dp.Cout = 1;
    expect_val(SEL_BUS, 64'h0003_8000);
    settle();

    // AND R4,R3,R7
    clear_strobes();
    dp.R3out = 1; dp.Yin = 1;
    expect_val(SEL_Y, 64'h22);
    tick();
    clear_strobes();
    dp.R7out = 1; dp.AND = 1; dp.Zin = 1; dp.operation = 5'b00101;
    expect_val(SEL_Z, 64'h20);
    tick();
    clear_strobes();
    dp.Zlowout = 1; dp.R4in = 1;
    expect_val(SEL_R4, 64'h20);
    tick();

    // Priority encoder
    clear_strobes();
    dp.R3out = 1; dp.PCout = 1;
    expect_val(SEL_BUS, 64'd1);
    expect_val(SEL_ENC, 64'h0010_0008);
    settle();
    clear_strobes();
    expect_val(SEL_BUS, 64'd0);
    expect_val(SEL_ENC, 64'd0);
    settle();

    // Constant with IR[18] set
    load_mdr(32'h0004_0000);
    clear_strobes();
    dp.MDRout = 1; dp.IRin = 1;
    expect_val(SEL_IR, 64'h0004_0000);
    tick();
    clear_strobes();
    dp.Cout = 1;
    expect_val(SEL_BUS, 64'hFFFC_0000);
    settle();

    // IncPC takes priority over AND and ignores the opcode (Y = 0x22)
    clear_strobes();
    dp.R3out = 1; dp.IncPC = 1; dp.AND = 1; dp.Zin = 1;
    dp.operation = 5'bxxxxx;
    expect_val(SEL_Z, 64'h23);
    tick();

    // ALU opcode sweep
    for (int p = 0; p < 2; p++) begin
      load_mdr(pair_a[p]);
      clear_strobes();
      dp.MDRout = 1; dp.Yin = 1;
      expect_val(SEL_Y, {32'd0, pair_a[p]});
      tick();
      load_mdr(pair_b[p]);
      for (int k = 0; k < 15; k++) begin
        clear_strobes();
        dp.MDRout = 1; dp.Zin = 1; dp.operation = ops[k];
        exp_z = alu_model(ops[k], pair_a[p], pair_b[p]);
        expect_val(SEL_Z, exp_z);
        tick();
      end
    end

    // Z sources the bus and reloads in the same cycle
    for (int k = 0; k < 2; k++) begin
      clear_strobes();
      dp.Zlowout = 1; dp.IncPC = 1; dp.Zin = 1;
      exp_z = {32'd0, exp_z[31:0] + 32'd1};
      expect_val(SEL_Z, exp_z);
      tick();
    end

    // Asynchronous clear mid-cycle, loads held off while low
    load_mdr(32'h0000_0077);
    clear_strobes();
    dp.MDRout = 1; dp.R3in = 1; dp.R7in = 1; dp.Yin = 1; dp.PCin = 1;
    dp.Zin = 1; dp.IncPC = 1;
    #3 Clear = 1'b0;
    expect_val(SEL_MDR, 64'd0);
    expect_val(SEL_R3, 64'd0);
    expect_val(SEL_PC, 64'd0);
    expect_val(SEL_Z, 64'd0);
    expect_val(SEL_IR, 64'd0);
    settle();
    clear_strobes();
    dp.Mdatain = 32'h55; dp.Read = 1; dp.MDRin = 1;
    dp.Cout = 1; dp.R3in = 1; dp.Yin = 1; dp.IncPC = 1; dp.Zin = 1;
    expect_val(SEL_MDR, 64'd0);
    expect_val(SEL_R3, 64'd0);
    expect_val(SEL_Y, 64'd0);
    expect_val(SEL_Z, 64'd0);
    tick();
    Clear = 1'b1;
    expect_val(SEL_MDR, 64'h55);
    expect_val(SEL_Z, 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
